// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: three-requester write arbiter with lock support and a registered write stage
//
// Ports:
//   I_CLK        clock, rising edge
//   I_NRESET     asynchronous active-low reset
//   I_STALL      suppresses all grants; state, LAST and owner hold
//   I_REQ_VALID  per-requester write request
//   I_REQ_LOCK   per-requester lock request, sampled on a transfer
//   I_REQ_ADDR   per-requester address, requester i in slice i
//   I_REQ_DATA   per-requester data, requester i in slice i
//   O_REQ_READY  per-requester grant (at most one hot)
//   O_WR_EN      one-hot register enable, one cycle after the transfer
//   O_WR_DATA    write data broadcast, holds its last value when idle
//   O_LOCKED     high while the arbiter is locked to one owner
//   O_R0_DROP    pulse marking a dropped address-0 write
//
// Optional feature: define REGFILE_ARB_R0_PROTECT_EN to make address 0 read-only
// (writes are accepted but dropped, with an O_R0_DROP pulse).
module regfile_write_arbiter #(
    parameter int P_WIDTH    = 16,
    parameter int P_NUM_REGS = 16
) (
    input  logic                                                      I_CLK,
    input  logic                                                      I_NRESET,
    input  logic                                                      I_STALL,
    input  logic [2:0]                                                I_REQ_VALID,
    input  logic [2:0]                                                I_REQ_LOCK,
    input  logic [3*((P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1)-1:0] I_REQ_ADDR,
    input  logic [3*P_WIDTH-1:0]                                      I_REQ_DATA,
    output logic [2:0]                                                O_REQ_READY,
    output logic [P_NUM_REGS-1:0]                                     O_WR_EN,
    output logic [P_WIDTH-1:0]                                        O_WR_DATA,
    output logic                                                      O_LOCKED,
    output logic                                                      O_R0_DROP
);
    localparam int AW = (P_NUM_REGS > 1) ? $clog2(P_NUM_REGS) : 1;

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              last_q, last_d;
    logic [1:0]              owner_q, owner_d;
    logic [P_NUM_REGS-1:0]   wr_en_q, wr_en_d;
    logic [P_WIDTH-1:0]      wr_data_q, wr_data_d;
    logic [3:0]              vld4, lock4;
    logic [1:0]              start, idx, gidx;
    logic [2:0]              sum;
    logic                    found;
    logic [AW-1:0]           sel_addr;
    logic [P_WIDTH-1:0]      sel_data;

    // Padding to 4 bits lets a 2-bit index address the vectors without range issues.
    assign vld4  = {1'b0, I_REQ_VALID};
    assign lock4 = {1'b0, I_REQ_LOCK};

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q <= ARB;
            last_q  <= 2'd2;
            owner_q <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
        end
    end

    // A grant is always a transfer, because ready only rises for a valid requester.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        if (found) begin
            last_d = gidx;
            if (state_q == ARB && lock4[gidx]) begin
                state_d = LOCKED;
                owner_d = gidx;
            end else if (state_q == LOCKED && !lock4[gidx]) begin
                state_d = ARB;
            end
        end
    end

    // Round-robin search starting just after LAST; in LOCKED only the owner may win.
    always_comb begin
        start = (last_q >= 2'd2) ? 2'd0 : last_q + 2'd1;
        found = 1'b0;
        gidx  = 2'd0;
        sum   = 3'd0;
        idx   = 2'd0;
        if (I_NRESET && !I_STALL) begin
            if (state_q == LOCKED) begin
                found = vld4[owner_q];
                gidx  = owner_q;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    sum = {1'b0, start} + 3'(k);
                    idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                    if (!found && vld4[idx]) begin
                        found = 1'b1;
                        gidx  = idx;
                    end
                end
            end
        end
        O_REQ_READY = found ? (3'b001 << gidx) : 3'b000;
        O_LOCKED    = (state_q == LOCKED);
    end

    assign sel_addr = (gidx == 2'd2) ? I_REQ_ADDR[2*AW +: AW] :
                      (gidx == 2'd1) ? I_REQ_ADDR[AW +: AW]   : I_REQ_ADDR[0 +: AW];
    assign sel_data = (gidx == 2'd2) ? I_REQ_DATA[2*P_WIDTH +: P_WIDTH] :
                      (gidx == 2'd1) ? I_REQ_DATA[P_WIDTH +: P_WIDTH]   : I_REQ_DATA[0 +: P_WIDTH];

`ifdef REGFILE_ARB_R0_PROTECT_EN
    localparam int R0_FIRST = 1;
    logic r0_drop_q;

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            r0_drop_q <= 1'b0;
        end else begin
            r0_drop_q <= found && (sel_addr == '0);
        end
    end

    assign O_R0_DROP = r0_drop_q;
`else
    localparam int R0_FIRST = 0;

    assign O_R0_DROP = 1'b0;
`endif

    // Addresses beyond P_NUM_REGS match no bit, so they produce an all-zero enable.
    always_comb begin
        wr_en_d = '0;
        for (int r = R0_FIRST; r < P_NUM_REGS; r++) begin
            wr_en_d[r] = found && (sel_addr == AW'(r));
        end
        wr_data_d = found ? sel_data : wr_data_q;
    end

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign O_WR_EN   = wr_en_q;
    assign O_WR_DATA = wr_data_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  valid = '0;
    logic [2:0]  lock = '0;
    logic [3:0]  a0 = 4'd1, a1 = 4'd2, a2 = 4'd3;
    logic [15:0] d0 = 16'h1111, d1 = 16'h2222, d2 = 16'h3333;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  ready;
    logic [15:0] wr_en;
    logic [15:0] wr_data;
    logic        locked;
    logic        r0_drop;
    logic [15:0] dexp [3];
    int          checks = 0;
    int          errors = 0;

    assign req_addr = {a2, a1, a0};
    assign req_data = {d2, d1, d0};

    regfile_write_arbiter #(.P_WIDTH(16), .P_NUM_REGS(16)) dut (
        .I_CLK       (clk),
        .I_NRESET    (nrst),
        .I_STALL     (stall),
        .I_REQ_VALID (valid),
        .I_REQ_LOCK  (lock),
        .I_REQ_ADDR  (req_addr),
        .I_REQ_DATA  (req_data),
        .O_REQ_READY (ready),
        .O_WR_EN     (wr_en),
        .O_WR_DATA   (wr_data),
        .O_LOCKED    (locked),
        .O_R0_DROP   (r0_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        dexp[0] = 16'h1111;
        dexp[1] = 16'h2222;
        dexp[2] = 16'h3333;
        valid = 3'b111;
        tick();
        check("rst_ready", ready, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_locked", locked, 0);
        check("rst_drop", r0_drop, 0);
        nrst = 1'b1;
        #1;
        check("rr_first", ready, 3'b001);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_wr_en", wr_en, 32'h2 << (i % 3));
            check("rr_wr_data", wr_data, dexp[i % 3]);
            check("rr_ready", ready, 3'b001 << ((i + 1) % 3));
        end
        valid = 3'b000;
        #1;
        check("idle_ready", ready, 0);
        tick();
        check("idle_wr_en", wr_en, 0);
        check("idle_data_hold", wr_data, 16'h1111);
        a1 = 4'd5;
        d1 = 16'h5555;
        valid = 3'b010;
        lock = 3'b010;
        #1;
        check("lock_req", ready, 3'b010);
        tick();
        check("lock_on", locked, 1);
        check("lock_wr_en", wr_en, 32'h0020);
        check("lock_wr_data", wr_data, 16'h5555);
        valid = 3'b101;
        lock = 3'b000;
        #1;
        check("lock_others", ready, 0);
        tick();
        check("lock_hold_noowner", locked, 1);
        check("lock_idle_wr_en", wr_en, 0);
        valid = 3'b111;
        lock = 3'b010;
        #1;
        check("lock_owner_only", ready, 3'b010);
        tick();
        check("lock_keep", locked, 1);
        check("lock_keep_wr_en", wr_en, 32'h0020);
        lock = 3'b000;
        #1;
        check("lock_release_req", ready, 3'b010);
        tick();
        check("unlocked", locked, 0);
        check("release_wr_en", wr_en, 32'h0020);
        check("after_release", ready, 3'b100);
        tick();
        stall = 1'b1;
        #1;
        check("pre_stall_wr_en", wr_en, 32'h0008);
        check("pre_stall_data", wr_data, 16'h3333);
        check("stall_ready", ready, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("stall_ready_hold", ready, 0);
            check("stall_wr_en", wr_en, 0);
        end
        stall = 1'b0;
        #1;
        check("post_stall_last", ready, 3'b001);
        a0 = 4'd0;
        d0 = 16'hBEEF;
        valid = 3'b001;
        #1;
        check("r0_ready", ready, 3'b001);
        tick();
`ifdef REGFILE_ARB_R0_PROTECT_EN
        check("r0_wr_en", wr_en, 0);
        check("r0_drop", r0_drop, 1);
`else
        check("r0_wr_en", wr_en, 32'h0001);
        check("r0_drop", r0_drop, 0);
`endif
        check("r0_data", wr_data, 16'hBEEF);
        valid = 3'b000;
        tick();
        check("r0_drop_end", r0_drop, 0);
        check("r0_wr_en_end", wr_en, 0);
        a0 = 4'd1;
        d0 = 16'h1111;
        valid = 3'b010;
        lock = 3'b010;
        #1;
        check("rl_req", ready, 3'b010);
        tick();
        check("rl_locked", locked, 1);
        check("rl_wr_en", wr_en, 32'h0020);
        valid = 3'b111;
        #1;
        check("rl_owner", ready, 3'b010);
        nrst = 1'b0;
        #1;
        check("rl_async_wr_en", wr_en, 0);
        check("rl_async_data", wr_data, 0);
        check("rl_async_locked", locked, 0);
        check("rl_async_ready", ready, 0);
        tick();
        check("rl_hold_wr_en", wr_en, 0);
        check("rl_hold_ready", ready, 0);
        nrst = 1'b1;
        lock = 3'b000;
        #1;
        check("rl_first_grant", ready, 3'b001);
        check("rl_no_stale_wr", wr_en, 0);
        tick();
        check("rl_wr_en", wr_en, 32'h0002);
        check("rl_wr_data", wr_data, 16'h1111);
        check("rl_unlocked", locked, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 16, meaning the data width of one register-file entry.
REQ-002 The block SHALL have parameter P_NUM_REGS, default 16, meaning the number of register-file entries; the address width is clog2(P_NUM_REGS).
REQ-003 I_CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-004 I_NRESET  input  1  reset, asynchronous, active-low.
REQ-005 I_STALL  input  1  when high, the block grants no requester.
REQ-006 I_REQ_VALID  input  3  per-requester write request; bit i belongs to requester i.
REQ-007 I_REQ_LOCK  input  3  per-requester lock request, sampled on a transfer.
REQ-008 I_REQ_ADDR  input  3*clog2(P_NUM_REGS)  per-requester target address, requester i in slice i.
REQ-009 I_REQ_DATA  input  3*P_WIDTH  per-requester write data, requester i in slice i.
REQ-010 O_REQ_READY  output  3  per-requester grant, at most one bit high.
REQ-011 O_WR_EN  output  P_NUM_REGS  one-hot per-register enable driving the register enables.
REQ-012 O_WR_DATA  output  P_WIDTH  data broadcast to all registers.
REQ-013 O_LOCKED  output  1  high while the arbiter is in state LOCKED.
REQ-014 O_R0_DROP  output  1  one-cycle pulse marking a dropped address-0 write.

Function
REQ-015 A transfer on requester i SHALL occur on a rising edge where I_REQ_VALID[i] and O_REQ_READY[i] are both high.
REQ-016 O_REQ_READY SHALL be combinational from I_REQ_VALID, I_STALL, the state and the priority pointer, and SHALL never assert for a requester whose valid bit is low.
REQ-017 In state ARB, the grant SHALL go to the first valid requester searching from (LAST+1) mod 3 upward; LAST is a 2-bit register updated to the granted index on each transfer.
REQ-018 A transfer with I_REQ_LOCK[i] high SHALL move the block from ARB to LOCKED with owner i; in LOCKED only the owner SHALL be granted.
REQ-019 A transfer by the owner with I_REQ_LOCK low SHALL return the block to ARB; owner valid low does not release the lock.
REQ-020 When I_STALL is high, O_REQ_READY SHALL be all zeros; state, LAST and owner SHALL hold.
REQ-021 The write stage SHALL be registered: a transfer in cycle N SHALL produce O_WR_EN one-hot at the transferred address and O_WR_DATA equal to the transferred data during cycle N+1 only.
REQ-022 Back-to-back transfers SHALL sustain one write per cycle with no bubble.
REQ-023 With no transfer in cycle N, O_WR_EN SHALL be all zeros in cycle N+1; O_WR_DATA SHALL hold its last value.
REQ-024 An address >= P_NUM_REGS SHALL be accepted and SHALL produce all-zero O_WR_EN.
REQ-025 I_STALL high SHALL NOT cancel a write already registered for the next cycle.

Reset
REQ-026 While I_NRESET is low, regardless of clock: O_WR_EN = 0, O_WR_DATA = 0, O_R0_DROP = 0, state = ARB, O_LOCKED = 0, LAST = 2, owner = 0, O_REQ_READY = 0.
REQ-027 With I_NRESET low mid-transfer or mid-lock, no write enable SHALL appear after release; the first grant after release SHALL follow REQ-017 from LAST = 2.

Configuration
REQ-028 Macro REGFILE_ARB_R0_PROTECT_EN defined: a transfer to address 0 SHALL be accepted normally, SHALL produce all-zero O_WR_EN in cycle N+1, and SHALL pulse O_R0_DROP high for that cycle.
REQ-029 Macro REGFILE_ARB_R0_PROTECT_EN undefined: address 0 SHALL be written like any other address, and O_R0_DROP SHALL be tied to 0.

Verification
REQ-030 All three valid continuously with addresses 1,2,3 and data 0x1111,0x2222,0x3333 -> grants 0,1,2,0,... one per cycle; O_WR_EN = 0x0002,0x0004,0x0008 one cycle after each grant.
REQ-031 Requester 1 transfers with LOCK=1, then requesters 0 and 2 valid -> O_LOCKED=1, only requester 1 granted; release transfer with LOCK=0 -> next grant to requester 2.
REQ-032 I_STALL=1 for 3 cycles with all valid -> O_REQ_READY = 0 for 3 cycles; a write from the cycle before the stall still appears; LAST is unchanged.
REQ-033 Requester 0 writes address 0 with data 0xBEEF -> with macro defined: O_WR_EN = 0 and O_R0_DROP = 1 for one cycle; without macro: O_WR_EN = 0x0001 and O_WR_DATA = 0xBEEF.
REQ-034 I_NRESET low in the same cycle as a transfer, and during LOCKED -> outputs zero immediately; O_LOCKED = 0; after release with all valid, requester 0 is granted first.
